spike_rate_decoder: RTL and testbench

- Converts a spike train from an LIF neuron into a spike count per fixed window. This is the rate-code reader, the reverse of the current-to-spike path.
- Sits after a neuron's spike output.
- Delivers one count word per window over a valid/ready handshake to downstream logic (classifier, readout, host).

---
 rtl/spike_rate_decoder.sv | 259 +++++++++++++++++++++++++
 tb/tb_spike_rate_decoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/spike_rate_decoder.sv
// ---------------------------------------------------------------------------
// spike_rate_decoder
//
// Rate-code reader for an LIF neuron spike train. Counts the spikes seen in
// consecutive windows of WINDOW clock cycles. At the end of each window it
// delivers the saturating count over a valid/ready handshake.
//
// Optional feature: define SPIKE_ISI_EN to add the isi_min port and the
// logic behind it. isi_min reports the minimum interval between two
// consecutive spikes in the window, in edges; all-ones means fewer than
// two spikes.
//
// Parameters:
//   WINDOW  window length in clock cycles (2 .. 2**16)
//   CNT_W   spike count width; the count saturates at 2**CNT_W-1
//   ISI_W   inter-spike-interval width (only with SPIKE_ISI_EN)
//
// Ports:
//   clk         rising-edge system clock
//   reset       asynchronous active-low reset
//   en          counting enable; dropping it discards the partial window
//   clear       synchronous clear of counters, result, valid and overrun
//   spike_in    one spike per cycle in which it is high
//   rate_data   spike count of the last completed window
//   rate_valid  rate_data holds an unconsumed result
//   rate_ready  downstream accepts rate_data
//   overrun     sticky: a result was overwritten before it was accepted
//   isi_min     minimum inter-spike interval (SPIKE_ISI_EN only)
// ---------------------------------------------------------------------------
module spike_rate_decoder #(
    parameter int WINDOW = 16,
    parameter int CNT_W  = 8
`ifdef SPIKE_ISI_EN
    ,
    parameter int ISI_W  = 8
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic             spike_in,
    output logic [CNT_W-1:0] rate_data,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             overrun
`ifdef SPIKE_ISI_EN
    ,
    output logic [ISI_W-1:0] isi_min
`endif
);

    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_COUNT = 1'b1
    } state_t;

    // Saturating add of a single bit to the spike count.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] value,
                                                     input logic inc);
        logic [CNT_W-1:0] result;
        if (value == CNT_MAX) begin
            result = value;
        end else begin
            result = value + {{(CNT_W-1){1'b0}}, inc};
        end
        return result;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIN_W-1:0] win_cnt_r;
    logic [WIN_W-1:0] win_base_s;
    logic [WIN_W-1:0] win_nxt_s;
    logic [CNT_W-1:0] spike_cnt_r;
    logic [CNT_W-1:0] spike_base_s;
    logic [CNT_W-1:0] spike_nxt_s;
    logic [CNT_W-1:0] spike_sum_s;
    logic             win_end_s;

`ifdef SPIKE_ISI_EN
    localparam logic [ISI_W-1:0] ISI_MAX = {ISI_W{1'b1}};

    // Saturating increment of an interval value.
    function automatic logic [ISI_W-1:0] isi_sat_inc(input logic [ISI_W-1:0] value);
        logic [ISI_W-1:0] result;
        if (value == ISI_MAX) begin
            result = value;
        end else begin
            result = value + {{(ISI_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

    // isi_cnt_r: edges since the last spike of this window (0 on the edge
    // right after a spike), so the interval ending on the current edge is
    // isi_cnt_r + 1. isi_seen_r marks that the window already had a spike.
    logic [ISI_W-1:0] isi_cnt_r;
    logic [ISI_W-1:0] isi_cnt_base_s;
    logic [ISI_W-1:0] isi_cnt_nxt_s;
    logic             isi_seen_r;
    logic             isi_seen_base_s;
    logic             isi_seen_nxt_s;
    logic [ISI_W-1:0] isi_run_r;
    logic [ISI_W-1:0] isi_run_base_s;
    logic [ISI_W-1:0] isi_run_nxt_s;
    logic [ISI_W-1:0] isi_interval_s;
    logic [ISI_W-1:0] isi_cand_s;
    logic [ISI_W-1:0] isi_run_upd_s;
`endif

    // Next-state and counter update; IDLE forces the counters to read as 0.
    always_comb begin
        state_nxt_s  = state_r;
        win_base_s   = {WIN_W{1'b0}};
        spike_base_s = {CNT_W{1'b0}};
        win_nxt_s    = {WIN_W{1'b0}};
        spike_nxt_s  = {CNT_W{1'b0}};
        win_end_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                win_base_s   = {WIN_W{1'b0}};
                spike_base_s = {CNT_W{1'b0}};
            end
            ST_COUNT: begin
                win_base_s   = win_cnt_r;
                spike_base_s = spike_cnt_r;
            end
            default: begin
                win_base_s   = {WIN_W{1'b0}};
                spike_base_s = {CNT_W{1'b0}};
            end
        endcase

        spike_sum_s = cnt_sat_inc(spike_base_s, spike_in);

        if (clear || !en) begin
            // Clear or enable drop: discard the partial window.
            state_nxt_s = ST_IDLE;
        end else begin
            state_nxt_s = ST_COUNT;
            if (win_base_s == WIN_LAST) begin
                // Last sample of the window; next edge is sample 0.
                win_end_s = 1'b1;
            end else begin
                win_nxt_s   = win_base_s + {{(WIN_W-1){1'b0}}, 1'b1};
                spike_nxt_s = spike_sum_s;
            end
        end
    end

`ifdef SPIKE_ISI_EN
    // Interval tracking and running minimum within the current window.
    always_comb begin
        isi_cnt_base_s  = {ISI_W{1'b0}};
        isi_seen_base_s = 1'b0;
        isi_run_base_s  = ISI_MAX;
        isi_cnt_nxt_s   = {ISI_W{1'b0}};
        isi_seen_nxt_s  = 1'b0;
        isi_run_nxt_s   = ISI_MAX;

        if (state_r == ST_COUNT) begin
            isi_cnt_base_s  = isi_cnt_r;
            isi_seen_base_s = isi_seen_r;
            isi_run_base_s  = isi_run_r;
        end else begin
            isi_cnt_base_s  = {ISI_W{1'b0}};
            isi_seen_base_s = 1'b0;
            isi_run_base_s  = ISI_MAX;
        end

        isi_interval_s = isi_sat_inc(isi_cnt_base_s);

        if (spike_in && isi_seen_base_s) begin
            isi_cand_s = isi_interval_s;
        end else begin
            isi_cand_s = ISI_MAX;
        end

        if (isi_cand_s < isi_run_base_s) begin
            isi_run_upd_s = isi_cand_s;
        end else begin
            isi_run_upd_s = isi_run_base_s;
        end

        if (state_nxt_s == ST_COUNT && !win_end_s) begin
            if (spike_in) begin
                isi_cnt_nxt_s = {ISI_W{1'b0}};
            end else begin
                isi_cnt_nxt_s = isi_interval_s;
            end
            isi_seen_nxt_s = isi_seen_base_s | spike_in;
            isi_run_nxt_s  = isi_run_upd_s;
        end else begin
            isi_cnt_nxt_s  = {ISI_W{1'b0}};
            isi_seen_nxt_s = 1'b0;
            isi_run_nxt_s  = ISI_MAX;
        end
    end
`endif

    // State and window counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            win_cnt_r   <= {WIN_W{1'b0}};
            spike_cnt_r <= {CNT_W{1'b0}};
`ifdef SPIKE_ISI_EN
            isi_cnt_r   <= {ISI_W{1'b0}};
            isi_seen_r  <= 1'b0;
            isi_run_r   <= {ISI_W{1'b1}};
`endif
        end else begin
            state_r     <= state_nxt_s;
            win_cnt_r   <= win_nxt_s;
            spike_cnt_r <= spike_nxt_s;
`ifdef SPIKE_ISI_EN
            isi_cnt_r   <= isi_cnt_nxt_s;
            isi_seen_r  <= isi_seen_nxt_s;
            isi_run_r   <= isi_run_nxt_s;
`endif
        end
    end

    // Result register, handshake and sticky overrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rate_data  <= {CNT_W{1'b0}};
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef SPIKE_ISI_EN
            isi_min    <= {ISI_W{1'b1}};
`endif
        end else if (clear) begin
            rate_data  <= {CNT_W{1'b0}};
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
`ifdef SPIKE_ISI_EN
            isi_min    <= {ISI_W{1'b1}};
`endif
        end else if (win_end_s) begin
            // A pending word that is not taken on this edge is lost.
            rate_data  <= spike_sum_s;
            rate_valid <= 1'b1;
            overrun    <= overrun | (rate_valid & ~rate_ready);
`ifdef SPIKE_ISI_EN
            isi_min    <= isi_run_upd_s;
`endif
        end else if (rate_valid && rate_ready) begin
            rate_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spike_rate_decoder.sv
module tb_spike_rate_decoder;

    localparam int WINDOW = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       clear = 1'b0;
    logic       spike_in = 1'b0;
    logic       rate_ready = 1'b0;

    logic [7:0] data0;
    logic       valid0;
    logic       ovr0;
    logic [2:0] data1;
    logic       valid1;
    logic       ovr1;
`ifdef SPIKE_ISI_EN
    logic [7:0] isi0;
    logic [7:0] isi1;
`endif

    int checks = 0;
    int failures = 0;

    // Behavioural model: samples of the current window plus expected outputs.
    bit win_q[$];
    int exp_data[2];
    bit exp_valid[2];
    bit exp_ovr[2];
    int exp_isi;
    int cap[2] = '{255, 7};

    always #5 clk = ~clk;

    spike_rate_decoder #(.WINDOW(WINDOW), .CNT_W(8)) u_main (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .spike_in(spike_in),
        .rate_data(data0), .rate_valid(valid0), .rate_ready(rate_ready), .overrun(ovr0)
`ifdef SPIKE_ISI_EN
        , .isi_min(isi0)
`endif
    );

    spike_rate_decoder #(.WINDOW(WINDOW), .CNT_W(3)) u_sat (
        .clk(clk), .reset(reset), .en(en), .clear(clear), .spike_in(spike_in),
        .rate_data(data1), .rate_valid(valid1), .rate_ready(rate_ready), .overrun(ovr1)
`ifdef SPIKE_ISI_EN
        , .isi_min(isi1)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        win_q.delete();
        for (int k = 0; k < 2; k++) begin
            exp_data[k]  = 0;
            exp_valid[k] = 1'b0;
            exp_ovr[k]   = 1'b0;
        end
        exp_isi = 255;
    endtask

    // Window result from the stored samples: count and min spike spacing.
    task automatic model_window(output int sum, output int isi);
        int last;
        sum  = 0;
        isi  = 255;
        last = -1;
        for (int i = 0; i < win_q.size(); i++) begin
            if (win_q[i]) begin
                sum++;
                if (last >= 0 && (i - last) < isi) isi = i - last;
                last = i;
            end
        end
    endtask

    task automatic model_edge(input bit e, input bit c, input bit s, input bit r);
        int sum;
        int isi;
        if (c) begin
            model_reset();
        end else if (e) begin
            win_q.push_back(s);
            if (win_q.size() == WINDOW) begin
                model_window(sum, isi);
                for (int k = 0; k < 2; k++) begin
                    if (exp_valid[k] && !r) exp_ovr[k] = 1'b1;
                    exp_data[k]  = (sum > cap[k]) ? cap[k] : sum;
                    exp_valid[k] = 1'b1;
                end
                exp_isi = isi;
                win_q.delete();
            end else begin
                for (int k = 0; k < 2; k++)
                    if (exp_valid[k] && r) exp_valid[k] = 1'b0;
            end
        end else begin
            win_q.delete();
            for (int k = 0; k < 2; k++)
                if (exp_valid[k] && r) exp_valid[k] = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("data_main", data0, exp_data[0]);
        check("valid_main", valid0, exp_valid[0]);
        check("overrun_main", ovr0, exp_ovr[0]);
        check("data_sat", data1, exp_data[1]);
        check("valid_sat", valid1, exp_valid[1]);
        check("overrun_sat", ovr1, exp_ovr[1]);
`ifdef SPIKE_ISI_EN
        check("isi_main", isi0, exp_isi);
        check("isi_sat", isi1, exp_isi);
`endif
    endtask

    // One clock edge: drive inputs, advance model, sample #1 after the edge.
    task automatic step(input bit e, input bit c, input bit s, input bit r);
        en = e;
        clear = c;
        spike_in = s;
        rate_ready = r;
        @(posedge clk);
        model_edge(e, c, s, r);
        #1;
        compare_all();
    endtask

    // Asynchronous reset pulse between edges.
    task automatic async_reset();
        reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        #1;
        reset = 1'b1;
    endtask

    int vcount;

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("reset_valid_lit", valid0, 32'd0);
        reset = 1'b1;

        // Reset mid-window with a result pending, then a fresh window.
        for (int i = 0; i < WINDOW + 7; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        check("pre_reset_valid_lit", valid0, 32'd1);
        async_reset();
        check("reset_data_lit", data0, 32'd0);
        check("reset_valid2_lit", valid0, 32'd0);
        for (int i = 0; i < WINDOW; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0);
            if (i == WINDOW - 2) check("no_early_result", valid0, 32'd0);
        end
        check("first_result_lit", data0, 32'd16);
        check("first_result_sat_lit", data1, 32'd7);

        // Clear drops the pending result.
        step(1'b1, 1'b1, 1'b1, 1'b0);
        check("clear_valid_lit", valid0, 32'd0);

        // Rate count: spike every 4th cycle, always ready.
        vcount = 0;
        for (int i = 0; i < 3 * WINDOW; i++) begin
            step(1'b1, 1'b0, (i % 4) == 0, 1'b1);
            if (valid0) vcount++;
            if (i == WINDOW - 1) check("rate4_lit", data0, 32'd4);
        end
        check("rate_valid_cycles_lit", vcount, 32'd3);
        check("rate_no_overrun_lit", ovr0, 32'd0);

        // Overrun: counts 3 then 5 without ready, then one transfer.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < WINDOW; i++) step(1'b1, 1'b0, i < 3, 1'b0);
        for (int i = 0; i < WINDOW; i++) step(1'b1, 1'b0, i < 5, 1'b0);
        check("ovr_data_lit", data0, 32'd5);
        check("ovr_flag_lit", ovr0, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_xfer_valid_lit", valid0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_sticky_lit", ovr0, 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("ovr_cleared_lit", ovr0, 32'd0);

        // Saturation on the 3-bit instance.
        for (int i = 0; i < 2 * WINDOW; i++) begin
            step(1'b1, 1'b0, 1'b1, 1'b1);
            if (i == WINDOW - 1 || i == 2 * WINDOW - 1) check("sat7_lit", data1, 32'd7);
        end

        // Enable drop discards the partial window.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("drop_no_result_lit", valid0, 32'd0);
        for (int i = 0; i < WINDOW; i++) step(1'b1, 1'b0, (i == 3) || (i == 9), 1'b0);
        check("drop_result_lit", data0, 32'd2);
        check("drop_valid_lit", valid0, 32'd1);

`ifdef SPIKE_ISI_EN
        // Spikes at 2, 5, 11 then a single-spike window.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < WINDOW; i++) step(1'b1, 1'b0, (i == 2) || (i == 5) || (i == 11), 1'b1);
        check("isi_count_lit", data0, 32'd3);
        check("isi_min_lit", isi0, 32'd3);
        for (int i = 0; i < WINDOW; i++) step(1'b1, 1'b0, i == 7, 1'b1);
        check("isi_single_lit", isi0, 32'd255);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) async_reset();
            step($urandom_range(0, 19) != 0, $urandom_range(0, 199) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
